// File: rtl/shreg_seq_ctrl.sv
// Command sequencer for the N-bit universal shift register: turns LOAD/SHIFT/ROTATE
// commands into registered ENB/MODO/DIR/D/S_IN sequences and returns the settled Q bus.
module shreg_seq_ctrl #(
  parameter int N    = 4,
  parameter int CNTW = 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            iCmdValid,
  output logic            oCmdReady,
  input  logic [1:0]      iCmd,
  input  logic [CNTW-1:0] iCount,
  input  logic            iDir,
  input  logic [N-1:0]    iData,
  input  logic            iSerial,
  input  logic [N-1:0]    iQ,
  output logic            ENB,
  output logic            MODO1,
  output logic            MODO0,
  output logic            DIR,
  output logic [N-1:0]    D,
  output logic            S_IN,
  output logic            oBusy,
  output logic            oDone,
  output logic [N-1:0]    oResult
);

  // Cycles with ENB=0 before sampling Q, covering the flop output delay and mux paths.
  localparam int SETTLE_CYC = 2;

  typedef enum logic [2:0] {IDLE, LOAD, STEP, SETTLE, DONE} state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      oCmdReady <= 1'b1;
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      ENB       <= 1'b0;
      MODO1     <= 1'b0;
      MODO0     <= 1'b0;
      DIR       <= 1'b0;
      S_IN      <= 1'b0;
      D         <= '0;
      oResult   <= '0;
      cnt       <= '0;
    end else begin
      oDone <= 1'b0;
      case (state)
        IDLE: begin
          if (iCmdValid) begin
            oCmdReady <= 1'b0;
            oBusy     <= 1'b1;
            case (iCmd)
              2'b00: begin
                state <= LOAD;
                ENB   <= 1'b1;
                MODO1 <= 1'b1;
                D     <= iData;
              end
              2'b01, 2'b10: begin
                if (iCount != '0) begin
                  state <= STEP;
                  ENB   <= 1'b1;
                  MODO1 <= 1'b0;
                  MODO0 <= iCmd[1];
                  DIR   <= iDir;
                  S_IN  <= iSerial;
                  cnt   <= iCount;
                end else begin
                  state <= DONE;
                  oDone <= 1'b1;
                end
              end
              default: begin
                state <= DONE;
                oDone <= 1'b1;
              end
            endcase
          end
        end
        LOAD: begin
          state <= SETTLE;
          ENB   <= 1'b0;
          cnt   <= CNTW'(SETTLE_CYC - 1);
        end
        STEP: begin
          // Stopping at 1 keeps the counter from ever wrapping.
          if (cnt == CNTW'(1)) begin
            state <= SETTLE;
            ENB   <= 1'b0;
            cnt   <= CNTW'(SETTLE_CYC - 1);
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            state   <= DONE;
            oDone   <= 1'b1;
            oResult <= iQ;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          oCmdReady <= 1'b1;
          oBusy     <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          oCmdReady <= 1'b1;
          oBusy     <= 1'b0;
          ENB       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shreg_seq_ctrl.sv
// Directed bench for shreg_seq_ctrl with a behavioural shift register on the Q bus.
module tb_shreg_seq_ctrl;
  localparam int N = 4;
  localparam int CNTW = 3;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            iCmdValid = 1'b0;
  logic            oCmdReady;
  logic [1:0]      iCmd = 2'b11;
  logic [CNTW-1:0] iCount = '0;
  logic            iDir = 1'b0;
  logic [N-1:0]    iData = '0;
  logic            iSerial = 1'b0;
  logic [N-1:0]    iQ;
  logic            ENB, MODO1, MODO0, DIR, S_IN, oBusy, oDone;
  logic [N-1:0]    D, oResult;

  int checks = 0;
  int failures = 0;

  always #10 CLK = ~CLK;

  shreg_seq_ctrl #(.N(N), .CNTW(CNTW)) dut (
    .CLK(CLK), .RST(RST), .iCmdValid(iCmdValid), .oCmdReady(oCmdReady),
    .iCmd(iCmd), .iCount(iCount), .iDir(iDir), .iData(iData), .iSerial(iSerial),
    .iQ(iQ), .ENB(ENB), .MODO1(MODO1), .MODO0(MODO0), .DIR(DIR), .D(D),
    .S_IN(S_IN), .oBusy(oBusy), .oDone(oDone), .oResult(oResult)
  );

  // Stand-in for the shift register: DIR=1 moves bits toward the MSB, Q settles 5 units late.
  logic [N-1:0] q_reg = '0;
  logic [N-1:0] q_nxt;
  assign iQ = q_reg;
  always @(posedge CLK) begin
    if (ENB) begin
      if (MODO1)      q_nxt = D;
      else if (DIR)   q_nxt = {q_reg[N-2:0], MODO0 ? q_reg[N-1] : S_IN};
      else            q_nxt = {MODO0 ? q_reg[0] : S_IN, q_reg[N-1:1]};
      #5 q_reg = q_nxt;
    end
  end

  function automatic logic [N-1:0] ref_op(input logic [N-1:0] q, input logic [1:0] cmd,
                                          input int k, input logic dir, input logic ser);
    logic [N-1:0] r;
    r = q;
    for (int i = 0; i < k; i++) begin
      if (dir) r = {r[N-2:0], (cmd == 2'b10) ? r[N-1] : ser};
      else     r = {(cmd == 2'b10) ? r[0] : ser, r[N-1:1]};
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]      cmd;
    logic [CNTW-1:0] cnt;
    logic            dir;
    logic [N-1:0]    data;
    logic            ser;
    int              lat;
    int              enbs;
    logic [N-1:0]    res;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input int idx, input vec_t v);
    int lat, enbs;
    bit seen;
    @(negedge CLK);
    chk($sformatf("v%0d_ready", idx), oCmdReady, 1);
    iCmdValid = 1'b1; iCmd = v.cmd; iCount = v.cnt; iDir = v.dir;
    iData = v.data; iSerial = v.ser;
    @(posedge CLK);
    #1 iCmdValid = 1'b0;
    lat = 0; enbs = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(negedge CLK);
      lat++;
      if (ENB) begin
        enbs++;
        if (v.cmd == 2'b00) begin
          chk($sformatf("v%0d_load_mode", idx), {MODO1, D}, {1'b1, v.data});
        end else begin
          chk($sformatf("v%0d_step_mode", idx), {MODO1, MODO0, DIR, S_IN},
              {1'b0, v.cmd[1], v.dir, v.ser});
        end
      end
      if (oDone) seen = 1;
    end
    chk($sformatf("v%0d_done_seen", idx), seen, 1);
    chk($sformatf("v%0d_latency", idx), lat, v.lat);
    chk($sformatf("v%0d_enb_cycles", idx), enbs, v.enbs);
    chk($sformatf("v%0d_result", idx), oResult, v.res);
    chk($sformatf("v%0d_busy_at_done", idx), oBusy, 1);
  endtask

  initial begin
    int dn, en;
    // cmd, cnt, dir, data, ser, latency, enb cycles, result
    vecs[0] = '{2'b00, 3'd0, 1'b0, 4'b1011, 1'b0, 4, 1, 4'b1011};
    vecs[1] = '{2'b10, 3'd3, 1'b1, 4'b0000, 1'b0, 6, 3, ref_op(4'b1011, 2'b10, 3, 1'b1, 1'b0)};
    vecs[2] = '{2'b01, 3'd4, 1'b0, 4'b1111, 1'b0, 7, 4, 4'b0000};
    vecs[3] = '{2'b00, 3'd5, 1'b1, 4'b0110, 1'b1, 4, 1, 4'b0110};
    vecs[4] = '{2'b01, 3'd0, 1'b1, 4'b1111, 1'b1, 1, 0, 4'b0110};
    vecs[5] = '{2'b11, 3'd6, 1'b1, 4'b1001, 1'b1, 1, 0, 4'b0110};
    vecs[6] = '{2'b01, 3'd2, 1'b1, 4'b0000, 1'b1, 5, 2, ref_op(4'b0110, 2'b01, 2, 1'b1, 1'b1)};
    vecs[7] = '{2'b10, 3'd7, 1'b0, 4'b0000, 1'b0, 10, 7, ref_op(4'b1011, 2'b10, 7, 1'b0, 1'b0)};

    // Reset held two cycles, with a command offered that must be ignored.
    iCmdValid = 1'b1; iCmd = 2'b00; iData = 4'b1111;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_in_reset_enb", ENB, 0);
    RST = 1'b0; iCmdValid = 1'b0;
    @(negedge CLK);
    chk("rst_ready_busy_done", {oCmdReady, oBusy, oDone}, 3'b100);
    chk("rst_ctrl_lines", {ENB, MODO1, MODO0, DIR, S_IN}, 5'b0);
    chk("rst_d_result", {D, oResult}, 8'h00);

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset in the 2nd STEP cycle of ROTATE 5; a command offered while busy must be refused.
    dn = 0; en = 0;
    @(negedge CLK);
    iCmdValid = 1'b1; iCmd = 2'b10; iCount = 3'd5; iDir = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_step1_enb", ENB, 1);
    chk("abort_ready_busy", {oCmdReady, oBusy}, 2'b01);
    iCmd = 2'b00; iData = 4'b0101;
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_step2_enb_mode", {ENB, MODO1, MODO0}, 3'b101);
    RST = 1'b1; iCmdValid = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_idle", {oCmdReady, oBusy, ENB, oDone}, 4'b1000);
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (oDone) dn++;
      if (ENB) en++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_no_enb", en, 0);
    chk("abort_result_cleared", oResult, 4'b0000);

    // Sequencer is usable again after the abort.
    run_vec(8, '{2'b00, 3'd0, 1'b0, 4'b1100, 1'b0, 4, 1, 4'b1100});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shreg_seq_ctrl.md
Name: shreg_seq_ctrl

Overview:
- Command sequencer that sits directly upstream of the N-bit universal shift register built from ff_d and left/mid/right mux cells.
- Accepts one command at a time over a valid/ready handshake: parallel load, serial shift, or rotate, each with a step count.
- Drives the register's ENB, MODO1, MODO0, DIR, D and S_IN lines.
- Samples the register's Q bus and returns it as the command result, with a one-cycle done pulse.

Parameters:
- N, 4, register width in bits.
- CNTW, 3, width of the step-count field; the maximum count is 2^CNTW-1.

Ports:
- CLK  input  1  single clock; all state updates on posedge CLK.
- RST  input  1  synchronous, active-high reset.
- iCmdValid  input  1  command present.
- oCmdReady  output  1  sequencer can accept a command.
- iCmd  input  2  00=LOAD, 01=SHIFT (serial), 10=ROTATE, 11=NOP.
- iCount  input  CNTW  number of shift/rotate steps; ignored for LOAD and NOP.
- iDir  input  1  direction for SHIFT/ROTATE, copied to DIR (1 selects the Qleft path).
- iData  input  N  parallel data for LOAD.
- iSerial  input  1  serial bit for SHIFT, held for every step.
- iQ  input  N  Q bus fed back from the shift register.
- ENB  output  1  register clock enable.
- MODO1  output  1  1 = parallel load of D.
- MODO0  output  1  with MODO1=0: 0 = serial input S_IN, 1 = circular Q_circ.
- DIR  output  1  shift direction.
- D  output  N  parallel load data.
- S_IN  output  1  serial input bit.
- oBusy  output  1  command in progress.
- oDone  output  1  one-cycle pulse when a command completes.
- oResult  output  N  register contents captured at completion.

Behaviour:
- Reset (RST=1 at posedge CLK):
  - state=IDLE.
  - oCmdReady=1, oBusy=0, oDone=0.
  - ENB=0, MODO1=0, MODO0=0, DIR=0, S_IN=0.
  - D=0, oResult=0, step counter=0.
  - Reset overrides everything, including a mid-command state: the command is aborted with no oDone.
- Handshake:
  - A command is accepted on a posedge where iCmdValid=1, oCmdReady=1 and RST=0.
  - iCmd, iCount, iDir, iData and iSerial are latched at that edge.
  - oCmdReady=1 only in IDLE.
  - iCmdValid is ignored in every other state; a new command may be accepted on the cycle after the oDone pulse.
- States: IDLE, LOAD, STEP, SETTLE, DONE.
- IDLE -> LOAD if iCmd=00.
- IDLE -> STEP if iCmd is 01 or 10 and iCount!=0.
- IDLE -> DONE if iCmd=11, or if iCount=0 for SHIFT/ROTATE. In this case ENB is never asserted.
- LOAD (1 cycle):
  - ENB=1, MODO1=1, D=latched data.
  - Next state is SETTLE.
- STEP:
  - ENB=1, MODO1=0.
  - MODO0=0 for SHIFT, 1 for ROTATE.
  - DIR=latched dir; S_IN=latched serial.
  - The counter is loaded with iCount at acceptance and decrements each STEP cycle.
  - When the counter reaches 1 during a STEP cycle, the next state is SETTLE.
  - Exactly iCount cycles with ENB=1 are produced (iCount=7 gives 7 cycles).
- SETTLE:
  - ENB=0; the mode lines hold their last values.
  - Waits SETTLE_CYC=2 cycles so the ff_d #5 output delay and the mux propagation resolve before sampling.
  - On the last SETTLE cycle, oResult<=iQ and the next state is DONE.
- DONE (1 cycle):
  - oDone=1, ENB=0.
  - Next state is IDLE.
- oBusy=1 in every state except IDLE.
- Outputs are registered. The control lines change on posedge CLK and are stable for the whole following cycle, so they meet the register's 20-unit setup window relative to its next edge.
- ENB is never 1 outside LOAD and STEP.
- MODO1/MODO0/DIR/D/S_IN are don't-care functionally while ENB=0, but are held stable: they change only on the state entry edge.
- Latency from command acceptance to oDone:
  - LOAD: 4 cycles.
  - SHIFT/ROTATE with count k>0: k+3 cycles.
  - NOP or count 0: 1 cycle.
- The step counter is CNTW bits; no wrap-around occurs because decrement stops at 1.

Test Plan:
1. RST held 2 cycles, then released -> all outputs at their reset values, oCmdReady=1, no ENB activity.
2. LOAD iData=4'b1011 -> exactly 1 cycle ENB=1 with MODO1=1, D=1011; oDone 4 cycles after acceptance; oResult=1011.
3. After test 2, ROTATE iCount=3, iDir=1 -> 3 ENB cycles with MODO1=0, MODO0=1, DIR=1; oDone at +6; oResult equals 1011 rotated 3 positions in the DIR=1 direction (compare against a reference model).
4. SHIFT iCount=4, iSerial=0, iDir=0 -> 4 ENB cycles with MODO0=0, S_IN=0; oResult=0000.
5. SHIFT iCount=0, then NOP -> each gives oDone 1 cycle after acceptance; ENB stays 0; oResult is refreshed from iQ only in SETTLE, so it is unchanged.
6. RST asserted in the 2nd STEP cycle of ROTATE iCount=5 -> next edge: IDLE, ENB=0, no oDone; iCmdValid asserted while busy is never accepted (oCmdReady=0).
